sevenseg_scanner: RTL and testbench

- Time-multiplexed driver for a common-segment seven-segment display with `NDIGITS` BCD digits.
- Holds a frame of digit values and shares one `sevenseg` decoder across all digits.
- Steps a one-hot digit enable through the digits, with a blanking gap before each digit to suppress ghosting.
- Accepts new frames over a valid/ready handshake and applies them only at frame boundaries, so a frame is never shown half old and half new.

---
 rtl/sevenseg_pkg.sv | 14 +
 rtl/sevenseg.sv | 25 ++
 rtl/sevenseg_scanner.sv | 148 ++++++++++++++
 tb/tb_sevenseg_scanner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scanner and its decoder.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BLANKING = 2'd1,
        ON       = 2'd2
    } scan_state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

endpackage

// File: rtl/sevenseg.sv
// BCD to seven-segment decoder, active-high, bit6 = a .. bit0 = g; 10..15 blank.
module sevenseg
    import sevenseg_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed BCD display driver with per-slot blanking and frame-boundary updates.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load_valid,
    input  logic [4*NDIGITS-1:0] load_data,
    output logic                 load_ready,
    output logic [6:0]           segments,
    output logic [NDIGITS-1:0]   digit_en,
    output logic                 frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NDIGITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

    scan_state_t state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          wrap;

    bcd_t [NDIGITS-1:0] shadow;
    bcd_t [NDIGITS-1:0] pending;
    logic               pending_full;
    logic               commit;
    logic [6:0]         dec_seg;
    logic               lz_blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = (BLANK == 0) ? ON : BLANKING;
                end
                BLANKING: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == BLANK_LAST)
                        state_nxt = ON;
                end
                ON: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (BLANK == 0) ? ON : BLANKING;
                        if (idx == IDX_LAST) begin
                            idx_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            idx_nxt = idx + IW'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // commit requires pending_full, so it never coincides with an accepted handshake
    assign commit     = pending_full && ((state == IDLE) || wrap);
    assign load_ready = !pending_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_full <= 1'b0;
            shadow       <= {NDIGITS{4'hF}};
            frame_done   <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (commit) begin
                shadow       <= pending;
                pending_full <= 1'b0;
            end else if (load_valid && !pending_full) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end
        end
    end

    sevenseg u_dec (
        .digit (shadow[idx]),
        .seg   (dec_seg)
    );

`ifdef SEVENSEG_LZB_EN
    logic [NDIGITS-1:0] zero_above;

    always_comb begin
        zero_above = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            zero_above[i] = 1'b1;
            for (int j = i; j < NDIGITS; j++)
                if (shadow[j] != 4'd0)
                    zero_above[i] = 1'b0;
        end
    end

    assign lz_blank = (idx != '0) && zero_above[idx];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        segments = SEG_BLANK;
        digit_en = '0;
        if (state == ON) begin
            digit_en = NDIGITS'(1) << idx;
            segments = lz_blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench for sevenseg_scanner against a time-based reference model.
module tb_sevenseg_scanner;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic           clk = 1'b0;
    logic           reset, enable, load_valid;
    logic [4*N-1:0] load_data;
    logic           load_ready, frame_done;
    logic [6:0]     segments;
    logic [N-1:0]   digit_en;

    always #5 clk = ~clk;

    sevenseg_scanner #(.NDIGITS(N), .PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    int tests = 0;
    int fails = 0;

    // Model: m_t counts cycles since scanning started; slot/digit/blank follow by arithmetic.
    bit          m_run;
    int          m_t;
    logic [3:0]  m_sh [N];
    logic [15:0] m_pend;
    bit          m_pfull;
    bit          m_fd;

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        return (v < 10) ? tbl[v] : 7'b0;
    endfunction

    // {segments, digit_en, load_ready, frame_done}
    function automatic logic [12:0] exp_out();
        logic [6:0]   s = '0;
        logic [N-1:0] d = '0;
        if (m_run && (m_t % P) >= B) begin
            int dg = (m_t / P) % N;
            bit lz = (dg > 0);
            for (int j = dg; j < N; j++) if (m_sh[j] != 0) lz = 0;
            d = N'(1) << dg;
`ifdef SEVENSEG_LZB_EN
            s = lz ? 7'b0 : dec(m_sh[dg]);
`else
            s = dec(m_sh[dg]);
`endif
        end
        return {s, d, !m_pfull, m_fd};
    endfunction

    task automatic tick(input bit v, input logic [15:0] d, input bit e, input bit r);
        bit wrap, commit;
        load_valid = v; load_data = d; enable = e; reset = r;
        @(posedge clk);
        if (r) begin
            m_run = 0; m_t = 0; m_pfull = 0; m_fd = 0;
            for (int i = 0; i < N; i++) m_sh[i] = 4'hF;
        end else begin
            wrap   = m_run && e && ((m_t % (N*P)) == N*P - 1);
            commit = m_pfull && (!m_run || wrap);
            if (commit) begin
                for (int i = 0; i < N; i++) m_sh[i] = m_pend[4*i +: 4];
                m_pfull = 0;
            end else if (v && !m_pfull) begin
                m_pend = d; m_pfull = 1;
            end
            m_fd = wrap;
            if (!e)          begin m_run = 0; m_t = 0; end
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else             m_t++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1, 16'h1111, 1, 1);
        tick(0, 16'h0000, 0, 1);
        tests++;
        if ({segments, digit_en, load_ready, frame_done} !== {7'b0, 4'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset: got seg=%b en=%b rdy=%b fd=%b, want 0/0/1/0",
                     segments, digit_en, load_ready, frame_done);
        end
        tick(0, 16'h0000, 0, 0);
    endtask

    task automatic test_scan();
        int fd_cnt = 0;
        tick(1, 16'h1234, 0, 0);
        tests++;
        if (load_ready !== 1'b0) begin
            fails++; $display("FAIL scan_ready: got %b want 0", load_ready);
        end
        for (int c = 0; c < 66; c++) begin
            logic [6:0]   ws = '0;
            logic [N-1:0] we = '0;
            tick(0, 16'($urandom), 1, 0);
            tests++;
            if ({segments, digit_en, load_ready, frame_done} !== exp_out()) begin
                fails++;
                $display("FAIL scan c=%0d: got %h want %h", c,
                         {segments, digit_en, load_ready, frame_done}, exp_out());
            end
            fd_cnt += frame_done;
            case (c)
                2:  begin ws = 7'b0110011; we = 4'b0001; end
                10: begin ws = 7'b1111001; we = 4'b0010; end
                18: begin ws = 7'b1101101; we = 4'b0100; end
                26: begin ws = 7'b0110000; we = 4'b1000; end
                default: ;
            endcase
            if (we != 0) begin
                tests++;
                if ({segments, digit_en} !== {ws, we}) begin
                    fails++;
                    $display("FAIL scan_digit c=%0d: got %b/%b want %b/%b", c, digit_en, segments, we, ws);
                end
            end
        end
        tests++;
        if (fd_cnt != 2) begin
            fails++; $display("FAIL frame_done_count: got %0d want 2", fd_cnt);
        end
    endtask

    task automatic test_midframe_load();
        bit seen = 0;
        for (int g = 0; g < 64 && (m_t % (N*P)) != 8; g++) tick(0, 16'h0, 1, 0);
        tick(1, 16'h5678, 1, 0);
        tick(1, 16'h9999, 1, 0);
        for (int c = 0; c < 40; c++) begin
            tests++;
            if ({segments, digit_en, load_ready, frame_done} !== exp_out()) begin
                fails++;
                $display("FAIL midload c=%0d: got %h want %h", c,
                         {segments, digit_en, load_ready, frame_done}, exp_out());
            end
            if (frame_done) seen = 1;
            tests++;
            if (load_ready !== seen) begin
                fails++; $display("FAIL midload_ready c=%0d: got %b want %b", c, load_ready, seen);
            end
            if (!seen && (m_t % (N*P)) == 18) begin
                tests++;
                if (segments !== 7'b1101101) begin
                    fails++; $display("FAIL midload_old2: got %b want 1101101", segments);
                end
            end
            if (seen && (m_t % (N*P)) == 26) begin
                tests++;
                if (segments !== 7'b1011011) begin
                    fails++; $display("FAIL midload_new3: got %b want 1011011", segments);
                end
            end
            tick(0, 16'($urandom), 1, 0);
        end
    endtask

    task automatic test_enable_drop();
        for (int g = 0; g < 64 && (m_t % (N*P)) != 20; g++) tick(0, 16'h0, 1, 0);
        tick(0, 16'h0, 0, 0);
        tests++;
        if ({segments, digit_en, frame_done} !== 12'b0) begin
            fails++; $display("FAIL en_drop: got seg=%b en=%b fd=%b want 0", segments, digit_en, frame_done);
        end
        for (int c = 0; c < 12; c++) begin
            tick(0, 16'h0, 1, 0);
            tests++;
            if ({segments, digit_en, load_ready, frame_done} !== exp_out()) begin
                fails++;
                $display("FAIL reenable c=%0d: got %h want %h", c,
                         {segments, digit_en, load_ready, frame_done}, exp_out());
            end
            if (c == 1 || c == 2) begin
                tests++;
                if (digit_en !== ((c == 2) ? 4'b0001 : 4'b0000)) begin
                    fails++; $display("FAIL reenable_start c=%0d: got %b", c, digit_en);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int g = 0; g < 64 && (m_t % (N*P)) != 12; g++) tick(0, 16'h0, 1, 0);
        tick(1, 16'h4321, 1, 0);
        tick(0, 16'h0, 1, 1);
        tests++;
        if ({segments, digit_en, load_ready, frame_done} !== {11'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: got seg=%b en=%b rdy=%b, want 0/0/1", segments, digit_en, load_ready);
        end
        tick(0, 16'h0, 0, 0);
        for (int c = 0; c < 34; c++) begin
            tick(0, 16'h0, 1, 0);
            tests++;
            if ({segments, digit_en, load_ready, frame_done} !== exp_out() || segments !== 7'b0) begin
                fails++;
                $display("FAIL reset_blank c=%0d: got %h want %h", c,
                         {segments, digit_en, load_ready, frame_done}, exp_out());
            end
        end
    endtask

    task automatic test_lzb();
        tick(0, 16'h0, 0, 0);
        tick(1, 16'h0070, 0, 0);
        for (int c = 0; c < 32; c++) begin
            logic [6:0] ws;
            tick(0, 16'h0, 1, 0);
            tests++;
            if ({segments, digit_en, load_ready, frame_done} !== exp_out()) begin
                fails++;
                $display("FAIL lzb c=%0d: got %h want %h", c,
                         {segments, digit_en, load_ready, frame_done}, exp_out());
            end
            if (c % 8 == 2) begin
`ifdef SEVENSEG_LZB_EN
                ws = (c == 2) ? 7'b1111110 : (c == 10) ? 7'b1110000 : 7'b0000000;
`else
                ws = (c == 10) ? 7'b1110000 : 7'b1111110;
`endif
                tests++;
                if (segments !== ws) begin
                    fails++; $display("FAIL lzb_digit c=%0d: got %b want %b", c, segments, ws);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            logic [15:0] d = 16'($urandom);
            bit v = ($urandom_range(0, 3) == 0);
            bit e = ($urandom_range(0, 79) != 0);
            bit r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < N; i++) d[4*i +: 4] = 4'($urandom_range(0, 9)) & (c[0] ? 4'hF : 4'h0);
            tick(v, d, e, r);
            tests++;
            if ({segments, digit_en, load_ready, frame_done} !== exp_out()) begin
                fails++;
                $display("FAIL random c=%0d: got %h want %h", c,
                         {segments, digit_en, load_ready, frame_done}, exp_out());
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_midframe_load();
        test_enable_drop();
        test_reset_mid();
        test_lzb();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
